// File: rtl/ts_null_rate_adapter_pkg.sv
// ts_pkg: constants shared by the TS null-rate adapter.
//   TS packet length, sync byte, null-packet PID and header bytes,
//   read-FSM state encoding and a helper returning null-packet bytes.
package ts_pkg;

    localparam int          TS_PKT_LEN = 188;
    localparam logic [7:0]  TS_SYNC    = 8'h47;
    localparam logic [12:0] NULL_PID   = 13'h1FFF;
    localparam logic [7:0]  LAST_IDX   = 8'(TS_PKT_LEN - 1);

    // Null header: sync, PUSI=0 + PID[12:8], PID[7:0], payload-only / CC=0.
    localparam logic [7:0] NULL_HDR0 = TS_SYNC;
    localparam logic [7:0] NULL_HDR1 = {3'b000, NULL_PID[12:8]};
    localparam logic [7:0] NULL_HDR2 = NULL_PID[7:0];
    localparam logic [7:0] NULL_HDR3 = 8'h10;
    localparam logic [7:0] NULL_FILL = 8'hFF;

    // Read-FSM state encoding.
    localparam logic [1:0] RD_IDLE = 2'd0;
    localparam logic [1:0] RD_DATA = 2'd1;
    localparam logic [1:0] RD_NULL = 2'd2;

    function automatic logic [7:0] null_byte(input logic [7:0] idx);
        case (idx)
            8'd0:    null_byte = NULL_HDR0;
            8'd1:    null_byte = NULL_HDR1;
            8'd2:    null_byte = NULL_HDR2;
            8'd3:    null_byte = NULL_HDR3;
            default: null_byte = NULL_FILL;
        endcase
    endfunction

endpackage

// File: rtl/ts_null_rate_adapter_if.sv
// ts_null_rate_adapter_if: byte-stream signals of the null-rate adapter.
//   data_in/ena_in/psync_in : input TS byte stream
//   out_req                 : downstream byte-slot request
//   data_out/ena_out/psync_out : constant-rate output TS byte stream
// slave = the adapter, master = the surrounding logic.
interface ts_null_rate_adapter_if;
    logic [7:0] data_in;
    logic       ena_in;
    logic       psync_in;
    logic       out_req;
    logic [7:0] data_out;
    logic       ena_out;
    logic       psync_out;

    modport master (
        output data_in, ena_in, psync_in, out_req,
        input  data_out, ena_out, psync_out
    );

    modport slave (
        input  data_in, ena_in, psync_in, out_req,
        output data_out, ena_out, psync_out
    );
endinterface

// File: rtl/ts_null_rate_adapter_byte_ram.sv
// ts_byte_ram: simple dual-port byte RAM, 2^AW x 8.
//   clk          : clock
//   we/waddr/wdata : write port
//   raddr/rdata  : read port, data registered (1-cycle latency)
module ts_byte_ram #(
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);
    logic [7:0] mem [0:(1 << AW) - 1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end
endmodule

// File: rtl/ts_null_rate_adapter.sv
// ts_null_rate_adapter: packet-aligned TS buffer that replays complete
// 188-byte packets on a downstream byte-slot strobe.
//   clk, rst     : clock, synchronous active-high reset
//   ts (slave)   : input byte stream, out_req, output byte stream
//   overflow     : 1-cycle pulse when an input packet is dropped
//   pkt_count    : complete packets waiting in the buffer
// Build option NULL_INSERT_EN: empty slots at a packet boundary emit a
// null packet (PID 0x1FFF); without it, output is bursty packets only.
//
// Read FSM:
//   state   | meaning
//   RD_IDLE | at a packet boundary, next out_req picks the source
//   RD_DATA | replaying a buffered packet from RAM
//   RD_NULL | emitting a null packet (NULL_INSERT_EN only)
module ts_null_rate_adapter
    import ts_pkg::*;
#(
    parameter int FIFO_AW = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    ts_null_rate_adapter_if.slave ts,
    output logic                  overflow,
    output logic [FIFO_AW-8:0]    pkt_count
);
    localparam int               PW         = FIFO_AW + 1;
    localparam logic [FIFO_AW:0] ROOM_LIMIT = PW'((1 << FIFO_AW) - TS_PKT_LEN);
    localparam logic [FIFO_AW:0] PTR_ONE    = PW'(1);
    localparam logic [FIFO_AW-8:0] CNT_ONE  = (FIFO_AW - 7)'(1);

    logic [FIFO_AW:0] wptr, cptr, rptr, wbase, used;
    logic [7:0]       wcnt, rcnt, ram_q, s1_null_byte;
    logic [1:0]       rd_state, rd_next;
    logic             drop, pkt_start, has_room, wr_en, commit;
    logic             take_data, take_null, take, pop;
    logic             s1_valid, s1_psync, s1_null;

    ts_byte_ram #(.AW(FIFO_AW)) u_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wbase[FIFO_AW-1:0]),
        .wdata (ts.data_in),
        .raddr (rptr[FIFO_AW-1:0]),
        .rdata (ram_q)
    );

    // A sync byte while a packet is open rewinds to the last committed
    // byte before the room check, so the abandoned bytes free their space.
    always_comb begin
        pkt_start = ts.ena_in & ts.psync_in;
        wbase     = (pkt_start && wcnt != 8'd0) ? cptr : wptr;
        used      = wbase - rptr;
        has_room  = (used <= ROOM_LIMIT);
        wr_en     = 1'b0;
        commit    = 1'b0;
        if (pkt_start) begin
            wr_en = has_room;
        end else if (ts.ena_in && wcnt != 8'd0 && !drop) begin
            wr_en  = 1'b1;
            commit = (wcnt == LAST_IDX);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr     <= '0;
            cptr     <= '0;
            wcnt     <= 8'd0;
            drop     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            overflow <= pkt_start & ~has_room;
            if (pkt_start) begin
                if (has_room) begin
                    wptr <= wbase + PTR_ONE;
                    wcnt <= 8'd1;
                    drop <= 1'b0;
                end else begin
                    wptr <= wbase;
                    wcnt <= 8'd0;
                    drop <= 1'b1;
                end
            end else if (wr_en) begin
                wptr <= wptr + PTR_ONE;
                if (commit) begin
                    cptr <= wptr + PTR_ONE;
                    wcnt <= 8'd0;
                end else begin
                    wcnt <= wcnt + 8'd1;
                end
            end
        end
    end

    // Source is chosen only in RD_IDLE, so packets are never split.
    always_comb begin
        take_data = 1'b0;
        take_null = 1'b0;
        case (rd_state)
            RD_IDLE: begin
                if (ts.out_req) begin
                    if (pkt_count != '0) take_data = 1'b1;
`ifdef NULL_INSERT_EN
                    else take_null = 1'b1;
`endif
                end
            end
            RD_DATA: take_data = ts.out_req;
`ifdef NULL_INSERT_EN
            RD_NULL: take_null = ts.out_req;
`endif
            default: ;
        endcase
        take    = take_data | take_null;
        pop     = take_data & (rd_state == RD_IDLE);
        rd_next = RD_DATA;
`ifdef NULL_INSERT_EN
        if (take_null) rd_next = RD_NULL;
`endif
        if (rcnt == LAST_IDX) rd_next = RD_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_state     <= RD_IDLE;
            rcnt         <= 8'd0;
            rptr         <= '0;
            pkt_count    <= '0;
            s1_valid     <= 1'b0;
            s1_psync     <= 1'b0;
            s1_null      <= 1'b0;
            s1_null_byte <= 8'h00;
            ts.ena_out   <= 1'b0;
            ts.psync_out <= 1'b0;
            ts.data_out  <= 8'h00;
        end else begin
            if (take_data) rptr <= rptr + PTR_ONE;
            if (take) begin
                rd_state <= rd_next;
                rcnt     <= (rcnt == LAST_IDX) ? 8'd0 : rcnt + 8'd1;
            end
            case ({commit, pop})
                2'b10:   pkt_count <= pkt_count + CNT_ONE;
                2'b01:   pkt_count <= pkt_count - CNT_ONE;
                default: ;
            endcase
            // Stage 1 lines up with the RAM read; stage 2 is the output.
            s1_valid     <= take;
            s1_psync     <= (rcnt == 8'd0);
            s1_null      <= take_null;
            s1_null_byte <= null_byte(rcnt);
            ts.ena_out   <= s1_valid;
            ts.psync_out <= s1_valid & s1_psync;
            ts.data_out  <= !s1_valid ? 8'h00 : (s1_null ? s1_null_byte : ram_q);
        end
    end
endmodule

// File: tb/tb_ts_null_rate_adapter.sv
module tb_ts_null_rate_adapter;
    localparam int FIFO_AW = 9;
    localparam int DEPTH   = 1 << FIFO_AW;
    localparam int PKT     = 188;
`ifdef NULL_INSERT_EN
    localparam bit NULL_EN = 1'b1;
`else
    localparam bit NULL_EN = 1'b0;
`endif

    typedef struct {
        int n_pkts;
        int exp_count;
        int exp_ovf;
    } fill_vec_t;

    logic clk = 1'b0;
    logic rst;
    logic overflow;
    logic [FIFO_AW-8:0] pkt_count;

    ts_null_rate_adapter_if bus();

    ts_null_rate_adapter #(.FIFO_AW(FIFO_AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .ts        (bus),
        .overflow  (overflow),
        .pkt_count (pkt_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: byte queues for committed data, the packet being
    // received and the packet being replayed.
    logic [7:0] commit_q[$];
    logic [7:0] part_q[$];
    logic [7:0] cur_q[$];
    bit         cur_data;
    bit         pend_v, pend_p;
    logic [7:0] pend_b;

    logic [7:0] got_q[$];
    bit         got_p[$];
    logic [7:0] sent_q[$];
    int         ovf_seen;
    fill_vec_t  fill_tab[5];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        commit_q.delete();
        part_q.delete();
        cur_q.delete();
        cur_data = 1'b0;
        pend_v = 1'b0;
        pend_p = 1'b0;
        pend_b = 8'h00;
    endtask

    task automatic model_step(input logic [7:0] d, input bit e, input bit p, input bit q,
                              output bit ovf);
        logic [7:0] done_q[$];
        int occ;
        ovf = 1'b0;
        if (e && p) begin
            part_q.delete();
            occ = commit_q.size() + (cur_data ? cur_q.size() : 0);
            if (DEPTH - occ >= PKT) part_q.push_back(d);
            else ovf = 1'b1;
        end else if (e && part_q.size() > 0) begin
            part_q.push_back(d);
            if (part_q.size() == PKT) begin
                done_q = part_q;
                part_q.delete();
            end
        end
        pend_v = 1'b0;
        pend_p = 1'b0;
        pend_b = 8'h00;
        if (q) begin
            if (cur_q.size() == 0) begin
                if (commit_q.size() >= PKT) begin
                    for (int i = 0; i < PKT; i++) cur_q.push_back(commit_q.pop_front());
                    cur_data = 1'b1;
                end else if (NULL_EN) begin
                    cur_q.push_back(8'h47);
                    cur_q.push_back(8'h1F);
                    cur_q.push_back(8'hFF);
                    cur_q.push_back(8'h10);
                    for (int i = 4; i < PKT; i++) cur_q.push_back(8'hFF);
                    cur_data = 1'b0;
                end
            end
            if (cur_q.size() > 0) begin
                pend_v = 1'b1;
                pend_p = (cur_q.size() == PKT);
                pend_b = cur_q.pop_front();
            end
        end
        foreach (done_q[i]) commit_q.push_back(done_q[i]);
    endtask

    task automatic tick(input bit r, input logic [7:0] d, input bit e, input bit p, input bit q);
        bit xv, xp, xo;
        logic [7:0] xb;
        xv = pend_v;
        xp = pend_p;
        xb = pend_b;
        xo = 1'b0;
        rst = r;
        bus.data_in = d;
        bus.ena_in = e;
        bus.psync_in = p;
        bus.out_req = q;
        if (r) begin
            model_reset();
            xv = 1'b0;
            xp = 1'b0;
        end else begin
            model_step(d, e, p, q, xo);
        end
        @(posedge clk);
        #1;
        chk("ena_out", int'(bus.ena_out), int'(xv));
        chk("psync_out", int'(bus.psync_out), int'(xv & xp));
        if (xv) chk("data_out", int'(bus.data_out), int'(xb));
        if (r) chk("reset_data_out", int'(bus.data_out), 0);
        chk("overflow", int'(overflow), int'(xo));
        chk("pkt_count", int'(pkt_count), commit_q.size() / PKT);
        if (bus.ena_out) begin
            got_q.push_back(bus.data_out);
            got_p.push_back(bus.psync_out);
        end
        if (overflow) ovf_seen++;
    endtask

    task automatic idle(input int n, input bit q);
        for (int i = 0; i < n; i++) tick(1'b0, 8'h00, 1'b0, 1'b0, q);
    endtask

    task automatic send_pkt(input logic [7:0] id, input bit q);
        logic [7:0] b;
        for (int i = 0; i < PKT; i++) begin
            b = (i == 0) ? 8'h47 : (i == 1) ? id : 8'($urandom_range(0, 255));
            sent_q.push_back(b);
            tick(1'b0, b, 1'b1, i == 0, q);
        end
    endtask

    initial begin
        int nbad, npk, src_idx;
        logic [7:0] data_q[$];
        logic [7:0] newp[$];
        logic [7:0] b;
        bit e, p, q, r;

        fill_tab[0] = '{0, 0, 0};
        fill_tab[1] = '{1, 1, 0};
        fill_tab[2] = '{2, 2, 0};
        fill_tab[3] = '{3, 2, 1};
        fill_tab[4] = '{4, 2, 2};

        model_reset();
        tick(1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("reset_ena_out", int'(bus.ena_out), 0);
        chk("reset_pkt_count", int'(pkt_count), 0);

        // Fill table: packets pushed with no output requests.
        foreach (fill_tab[k]) begin
            tick(1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
            ovf_seen = 0;
            for (int n = 0; n < fill_tab[k].n_pkts; n++) send_pkt(8'(8'h60 + n), 1'b0);
            idle(2, 1'b0);
            chk("fill_pkt_count", int'(pkt_count), fill_tab[k].exp_count);
            chk("fill_overflow_pulses", ovf_seen, fill_tab[k].exp_ovf);
        end

        // Output latency: one out_req, data two cycles later.
        tick(1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
        send_pkt(8'h21, 1'b0);
        idle(3, 1'b0);
        tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        chk("latency_cycle1_ena", int'(bus.ena_out), 0);
        tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("latency_cycle2_ena", int'(bus.ena_out), 1);
        chk("latency_cycle2_psync", int'(bus.psync_out), 1);
        chk("latency_cycle2_data", int'(bus.data_out), 8'h47);
        idle(190, 1'b1);

        // Three back-to-back packets with continuous requests.
        tick(1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
        got_q.delete();
        got_p.delete();
        sent_q.delete();
        send_pkt(8'h01, 1'b1);
        send_pkt(8'h02, 1'b1);
        send_pkt(8'h03, 1'b1);
        idle(800, 1'b1);
        data_q.delete();
        npk = 0;
        nbad = 0;
        for (int i = 0; i + PKT <= got_q.size(); i += PKT) begin
            for (int j = 0; j < PKT; j++) if (got_p[i + j] != (j == 0)) nbad++;
            if (got_q[i + 1] != 8'h1F) begin
                npk++;
                for (int j = 0; j < PKT; j++) data_q.push_back(got_q[i + j]);
            end
        end
        chk("b2b_psync_positions", nbad, 0);
        chk("b2b_data_packets", npk, 3);
        nbad = 0;
        for (int i = 0; i < 3 * PKT; i++)
            if (i >= data_q.size() || data_q[i] != sent_q[i]) nbad++;
        chk("b2b_byte_mismatches", nbad, 0);
`ifndef NULL_INSERT_EN
        chk("b2b_total_bytes", got_q.size(), 3 * PKT);
`endif

        // Sync byte at position 100 abandons the partial packet.
        tick(1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 99; i++) tick(1'b0, (i == 0) ? 8'h47 : 8'h5A, 1'b1, i == 0, 1'b0);
        newp.delete();
        for (int i = 0; i < PKT; i++) begin
            b = (i == 0) ? 8'h47 : 8'($urandom_range(0, 255));
            newp.push_back(b);
            tick(1'b0, b, 1'b1, i == 0, 1'b0);
            if (i == PKT - 2) chk("trunc_count_before_last", int'(pkt_count), 0);
        end
        chk("trunc_count_after_last", int'(pkt_count), 1);
        got_q.delete();
        got_p.delete();
        idle(200, 1'b1);
        chk("trunc_out_len_ok", int'(got_q.size() >= PKT), 1);
        nbad = 0;
        for (int i = 0; i < PKT; i++) if (i >= got_q.size() || got_q[i] != newp[i]) nbad++;
        chk("trunc_packet_bytes", nbad, 0);

`ifdef NULL_INSERT_EN
        // Continuous requests with no input: repeated null packets.
        tick(1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
        got_q.delete();
        got_p.delete();
        idle(380, 1'b1);
        chk("null_b0", int'(got_q[0]), 8'h47);
        chk("null_b1", int'(got_q[1]), 8'h1F);
        chk("null_b2", int'(got_q[2]), 8'hFF);
        chk("null_b3", int'(got_q[3]), 8'h10);
        chk("null_b187", int'(got_q[187]), 8'hFF);
        chk("null_next_sync", int'(got_q[188]), 8'h47);
        chk("null_next_psync", int'(got_p[188]), 1);
        chk("null_pkt_count", int'(pkt_count), 0);

        // Packet completes while a null packet is 50 bytes in.
        tick(1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
        got_q.delete();
        got_p.delete();
        for (int i = 0; i < PKT; i++)
            tick(1'b0, (i == 0) ? 8'h47 : (i == 1) ? 8'h31 : 8'hA5, 1'b1, i == 0, i >= 138);
        idle(400, 1'b1);
        nbad = 0;
        for (int j = 1; j < PKT; j++) if (got_p[j]) nbad++;
        chk("midnull_null_unbroken", nbad, 0);
        chk("midnull_null_pid", int'(got_q[1]), 8'h1F);
        chk("midnull_null_tail", int'(got_q[187]), 8'hFF);
        chk("midnull_data_psync", int'(got_p[188]), 1);
        chk("midnull_data_id", int'(got_q[189]), 8'h31);
`else
        // Requests with an empty buffer produce nothing.
        tick(1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
        got_q.delete();
        got_p.delete();
        idle(20, 1'b1);
        chk("empty_no_output", got_q.size(), 0);
`endif

        // Reset while a packet is being replayed.
        tick(1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
        send_pkt(8'h41, 1'b0);
        idle(2, 1'b0);
        idle(60, 1'b1);
        tick(1'b1, 8'h00, 1'b0, 1'b0, 1'b1);
        chk("rst_mid_ena", int'(bus.ena_out), 0);
        chk("rst_mid_count", int'(pkt_count), 0);
        tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
`ifdef NULL_INSERT_EN
        chk("rst_restart_psync", int'(bus.psync_out), 1);
`else
        chk("rst_restart_quiet", int'(bus.ena_out), 0);
`endif
        idle(200, 1'b1);

        // Randomized traffic against the model, one reset in the middle.
        tick(1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
        src_idx = 0;
        for (int c = 0; c < 4000; c++) begin
            r = (c == 2000);
            e = ($urandom_range(0, 3) != 0);
            p = 1'b0;
            b = 8'($urandom_range(0, 255));
            if (e) begin
                if (src_idx == 0) begin
                    if ($urandom_range(0, 9) != 0) begin
                        p = 1'b1;
                        b = 8'h47;
                        src_idx = 1;
                    end
                end else if ($urandom_range(0, 249) == 0) begin
                    p = 1'b1;
                    b = 8'h47;
                    src_idx = 1;
                end else begin
                    src_idx = (src_idx + 1) % PKT;
                end
            end
            if (r) src_idx = 0;
            q = ($urandom_range(0, 2) != 0);
            tick(r, b, e, p, q);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
